product_accumulator: RTL and testbench

// - Downstream consumer of the 8x8 array multiplier: takes its registered 16-bit product (Z_reg/o_valid).
// - Sums a frame of products and emits one saturated sum per frame over a valid/ready handshake.
// - i_ready gives backpressure, so the multiplier's issuer stalls while a result is held.
// - Frame ends after LEN products or on an early i_last.

---
 rtl/mul_acc_pkg.sv | 16 +
 rtl/sat_adder.sv | 20 ++
 rtl/product_accumulator.sv | 131 +++++++++++++
 tb/tb_product_accumulator.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/mul_acc_pkg.sv
// Shared types and widths for the 8x8 multiplier, its issuer and the
// product accumulator that consumes the multiplier's registered product.
package mul_acc_pkg;

    // Operand width of the array multiplier and width of its product.
    localparam int OP_W   = 8;
    localparam int PROD_W = 16;

    // Accumulator control states.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        HOLD = 2'd2
    } acc_state_e;

endpackage

// File: rtl/sat_adder.sv
// Zero-extending adder with saturation to all-ones.
// The carry out of ACC_W bits is reported as ovf and forces the sum to the
// maximum representable value, so an already-saturated accumulator stays put.
module sat_adder #(
    parameter int IN_W  = 16,
    parameter int ACC_W = 24
) (
    input  logic [ACC_W-1:0] acc,
    input  logic [IN_W-1:0]  data,
    output logic [ACC_W-1:0] sum,
    output logic             ovf
);

    logic [ACC_W:0] wide_s;

    assign wide_s = {1'b0, acc} + {{(ACC_W + 1 - IN_W){1'b0}}, data};
    assign ovf    = wide_s[ACC_W];
    assign sum    = ovf ? {ACC_W{1'b1}} : wide_s[ACC_W-1:0];

endmodule

// File: rtl/product_accumulator.sv
// Frame accumulator for multiplier products.
// Sums up to LEN unsigned products (or fewer when i_last arrives early),
// saturating at all-ones, and presents one result per frame over a
// valid/ready handshake. While a result is held, i_ready is low so the
// upstream issuer stalls.
module product_accumulator
    import mul_acc_pkg::*;
#(
    parameter  int IN_W  = PROD_W,
    parameter  int ACC_W = 24,
    parameter  int LEN   = 4,
    localparam int CNT_W = $clog2(LEN + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             i_valid,
    output logic             i_ready,
    input  logic [IN_W-1:0]  i_data,
    input  logic             i_last,
    output logic             o_valid,
    input  logic             o_ready,
    output logic [ACC_W-1:0] o_sum,
    output logic [CNT_W-1:0] o_count,
    output logic             o_ovf
);

    acc_state_e       state_r;
    logic [ACC_W-1:0] acc_r;
    logic [CNT_W-1:0] cnt_r;
    logic             ovf_r;
    logic             i_ready_r;
    logic             o_valid_r;
    logic [ACC_W-1:0] o_sum_r;
    logic [CNT_W-1:0] o_count_r;
    logic             o_ovf_r;

    logic [ACC_W-1:0] add_sum_s;
    logic             add_ovf_s;
    logic             ovf_next_s;
    logic [CNT_W-1:0] cnt_inc_s;
    logic             beat_s;
    logic             frame_end_s;

    sat_adder #(
        .IN_W  (IN_W),
        .ACC_W (ACC_W)
    ) u_sat_adder (
        .acc  (acc_r),
        .data (i_data),
        .sum  (add_sum_s),
        .ovf  (add_ovf_s)
    );

    // A beat only counts when the block is actually advertising ready.
    assign beat_s      = i_valid && i_ready_r && (state_r == ACC);
    assign cnt_inc_s   = cnt_r + {{(CNT_W - 1){1'b0}}, 1'b1};
    assign ovf_next_s  = ovf_r | add_ovf_s;
    assign frame_end_s = beat_s && ((cnt_inc_s == CNT_W'(LEN)) || i_last);

    assign i_ready = i_ready_r;
    assign o_valid = o_valid_r;
    assign o_sum   = o_sum_r;
    assign o_count = o_count_r;
    assign o_ovf   = o_ovf_r;

    // Control FSM, frame accumulator/counter and registered result outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r   <= IDLE;
            acc_r     <= {ACC_W{1'b0}};
            cnt_r     <= {CNT_W{1'b0}};
            ovf_r     <= 1'b0;
            i_ready_r <= 1'b0;
            o_valid_r <= 1'b0;
            o_sum_r   <= {ACC_W{1'b0}};
            o_count_r <= {CNT_W{1'b0}};
            o_ovf_r   <= 1'b0;
        end else if (clr) begin
            // Drop the partial frame and any held result; a beat offered now is refused.
            state_r   <= ACC;
            acc_r     <= {ACC_W{1'b0}};
            cnt_r     <= {CNT_W{1'b0}};
            ovf_r     <= 1'b0;
            i_ready_r <= 1'b1;
            o_valid_r <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    state_r   <= ACC;
                    i_ready_r <= 1'b1;
                end
                ACC: begin
                    if (frame_end_s) begin
                        o_sum_r   <= add_sum_s;
                        o_count_r <= cnt_inc_s;
                        o_ovf_r   <= ovf_next_s;
                        o_valid_r <= 1'b1;
                        i_ready_r <= 1'b0;
                        state_r   <= HOLD;
                        acc_r     <= {ACC_W{1'b0}};
                        cnt_r     <= {CNT_W{1'b0}};
                        ovf_r     <= 1'b0;
                    end else if (beat_s) begin
                        acc_r <= add_sum_s;
                        cnt_r <= cnt_inc_s;
                        ovf_r <= ovf_next_s;
                    end else begin
                        acc_r <= acc_r;
                    end
                end
                HOLD: begin
                    // Release the result one cycle after the handshake; no bypass.
                    if (o_ready) begin
                        o_valid_r <= 1'b0;
                        i_ready_r <= 1'b1;
                        state_r   <= ACC;
                    end else begin
                        o_valid_r <= 1'b1;
                    end
                end
                default: begin
                    state_r   <= IDLE;
                    i_ready_r <= 1'b0;
                    o_valid_r <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_product_accumulator.sv
// Self-checking bench for product_accumulator. Two instances share the same
// stimulus: one with ACC_W=24 and one with ACC_W=17 so saturation can be seen.
// The reference model keeps the accepted beats of a frame in a queue and sums
// them when the frame closes.
module tb_product_accumulator;

    localparam int LEN = 4;

    logic        clk = 1'b0;
    logic        rst, clr, i_valid, i_last, o_ready;
    logic [15:0] i_data;

    logic        i_ready_a, o_valid_a, o_ovf_a;
    logic [23:0] o_sum_a;
    logic [2:0]  o_count_a;
    logic        i_ready_b, o_valid_b, o_ovf_b;
    logic [16:0] o_sum_b;
    logic [2:0]  o_count_b;

    int total = 0;
    int bad   = 0;

    // reference model state
    bit          m_ready, m_valid, m_ovf_a, m_ovf_b;
    int unsigned m_sum_a, m_sum_b, m_count;
    int unsigned m_q[$];

    always #5 clk = ~clk;

    product_accumulator #(.IN_W(16), .ACC_W(24), .LEN(LEN)) dut_a (
        .clk(clk), .rst(rst), .clr(clr), .i_valid(i_valid), .i_ready(i_ready_a),
        .i_data(i_data), .i_last(i_last), .o_valid(o_valid_a), .o_ready(o_ready),
        .o_sum(o_sum_a), .o_count(o_count_a), .o_ovf(o_ovf_a));

    product_accumulator #(.IN_W(16), .ACC_W(17), .LEN(LEN)) dut_b (
        .clk(clk), .rst(rst), .clr(clr), .i_valid(i_valid), .i_ready(i_ready_b),
        .i_data(i_data), .i_last(i_last), .o_valid(o_valid_b), .o_ready(o_ready),
        .o_sum(o_sum_b), .o_count(o_count_b), .o_ovf(o_ovf_b));

    function automatic int unsigned max_of(input int w);
        return (32'd1 << w) - 32'd1;
    endfunction

    task automatic model_reset();
        m_ready = 1'b0; m_valid = 1'b0; m_q.delete();
        m_sum_a = 0; m_sum_b = 0; m_count = 0; m_ovf_a = 1'b0; m_ovf_b = 1'b0;
    endtask

    // Advance one clock; update the model from the inputs seen at the edge.
    task automatic tick();
        int unsigned tot;
        @(posedge clk);
        if (!rst) begin
            model_reset();
        end else if (clr) begin
            m_q.delete(); m_valid = 1'b0; m_ready = 1'b1;
        end else if (m_valid) begin
            if (o_ready) begin m_valid = 1'b0; m_ready = 1'b1; end
        end else if (!m_ready) begin
            m_ready = 1'b1;
        end else if (i_valid) begin
            m_q.push_back(int'(i_data));
            if (m_q.size() == LEN || i_last) begin
                tot = 0;
                foreach (m_q[k]) tot += m_q[k];
                m_sum_a = (tot > max_of(24)) ? max_of(24) : tot;
                m_ovf_a = (tot > max_of(24));
                m_sum_b = (tot > max_of(17)) ? max_of(17) : tot;
                m_ovf_b = (tot > max_of(17));
                m_count = m_q.size();
                m_valid = 1'b1; m_ready = 1'b0;
                m_q.delete();
            end
        end
        #1;
    endtask

    task automatic beat(input logic [15:0] d, input logic last);
        i_valid = 1'b1; i_data = d; i_last = last;
        tick();
        i_valid = 1'b0; i_last = 1'b0; i_data = 16'd0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        tick(); tick();
        total++; if ({i_ready_a, o_valid_a, o_ovf_a, i_ready_b, o_valid_b} !== 5'b0) begin bad++; $display("FAIL reset_flags: got %b want 00000", {i_ready_a, o_valid_a, o_ovf_a, i_ready_b, o_valid_b}); end
        total++; if (o_sum_a !== 24'd0 || o_count_a !== 3'd0) begin bad++; $display("FAIL reset_data: got sum=%0d cnt=%0d want 0 0", o_sum_a, o_count_a); end
        rst = 1'b1;
        #1;
        total++; if (i_ready_a !== 1'b0) begin bad++; $display("FAIL reset_idle: got i_ready=%0b want 0", i_ready_a); end
        tick();
        total++; if (i_ready_a !== 1'b1 || i_ready_b !== 1'b1) begin bad++; $display("FAIL reset_to_acc: got i_ready=%0b/%0b want 1", i_ready_a, i_ready_b); end
    endtask

    task automatic test_full_frame();
        o_ready = 1'b1;
        for (int i = 0; i < 3; i++) beat(16'd65025, 1'b0);
        total++; if (o_valid_a !== 1'b0) begin bad++; $display("FAIL full_early_valid: got %0b want 0", o_valid_a); end
        beat(16'd65025, 1'b0);
        total++; if (o_valid_a !== 1'b1 || i_ready_a !== 1'b0) begin bad++; $display("FAIL full_valid: got v=%0b r=%0b want 1 0", o_valid_a, i_ready_a); end
        total++; if (o_sum_a !== 24'd260100 || o_count_a !== 3'd4 || o_ovf_a !== 1'b0) begin bad++; $display("FAIL full_sum: got %0d/%0d/%0b want 260100/4/0", o_sum_a, o_count_a, o_ovf_a); end
        total++; if (o_sum_b !== 17'd131071 || o_ovf_b !== 1'b1) begin bad++; $display("FAIL full_sum17: got %0d/%0b want 131071/1", o_sum_b, o_ovf_b); end
        tick();
        total++; if (o_valid_a !== 1'b0 || i_ready_a !== 1'b1) begin bad++; $display("FAIL full_release: got v=%0b r=%0b want 0 1", o_valid_a, i_ready_a); end
    endtask

    task automatic test_early_last();
        beat(16'd225, 1'b0);
        beat(16'd510, 1'b1);
        total++; if (o_valid_a !== 1'b1 || o_sum_a !== 24'd735 || o_count_a !== 3'd2 || o_ovf_a !== 1'b0) begin bad++; $display("FAIL early_last: got v=%0b %0d/%0d/%0b want 1 735/2/0", o_valid_a, o_sum_a, o_count_a, o_ovf_a); end
        tick();
        beat(16'd9, 1'b1);
        total++; if (o_sum_a !== 24'd9 || o_count_a !== 3'd1) begin bad++; $display("FAIL last_on_first: got %0d/%0d want 9/1", o_sum_a, o_count_a); end
        tick();
    endtask

    task automatic test_saturation();
        beat(16'd65025, 1'b0); beat(16'd65025, 1'b0); beat(16'd65025, 1'b1);
        total++; if (o_sum_b !== 17'd131071 || o_count_b !== 3'd3 || o_ovf_b !== 1'b1) begin bad++; $display("FAIL sat17: got %0d/%0d/%0b want 131071/3/1", o_sum_b, o_count_b, o_ovf_b); end
        total++; if (o_sum_a !== 24'd195075 || o_ovf_a !== 1'b0) begin bad++; $display("FAIL sat24: got %0d/%0b want 195075/0", o_sum_a, o_ovf_a); end
        tick();
        for (int i = 0; i < 4; i++) beat(16'd1, 1'b0);
        total++; if (o_sum_b !== 17'd4 || o_ovf_b !== 1'b0 || o_count_b !== 3'd4) begin bad++; $display("FAIL sat_cleared: got %0d/%0b/%0d want 4/0/4", o_sum_b, o_ovf_b, o_count_b); end
        tick();
    endtask

    task automatic test_backpressure();
        o_ready = 1'b0;
        beat(16'd1000, 1'b0); beat(16'd2000, 1'b0); beat(16'd3000, 1'b0); beat(16'd4000, 1'b0);
        i_valid = 1'b1; i_data = 16'd7;
        for (int i = 0; i < 5; i++) begin
            tick();
            total++; if (o_valid_a !== 1'b1 || i_ready_a !== 1'b0 || o_sum_a !== 24'd10000 || o_count_a !== 3'd4) begin bad++; $display("FAIL bp_hold[%0d]: got v=%0b r=%0b sum=%0d cnt=%0d want 1 0 10000 4", i, o_valid_a, i_ready_a, o_sum_a, o_count_a); end
        end
        o_ready = 1'b1;
        tick();
        total++; if (o_valid_a !== 1'b0 || i_ready_a !== 1'b1) begin bad++; $display("FAIL bp_release: got v=%0b r=%0b want 0 1", o_valid_a, i_ready_a); end
        for (int i = 0; i < 4; i++) tick();
        i_valid = 1'b0;
        total++; if (o_valid_a !== 1'b1 || o_sum_a !== 24'd28 || o_count_a !== 3'd4) begin bad++; $display("FAIL bp_next: got v=%0b sum=%0d cnt=%0d want 1 28 4", o_valid_a, o_sum_a, o_count_a); end
        tick();
    endtask

    task automatic test_clr_rst();
        o_ready = 1'b0;
        beat(16'd100, 1'b0); beat(16'd100, 1'b0);
        clr = 1'b1; i_valid = 1'b1; i_data = 16'd100;
        tick();
        clr = 1'b0; i_valid = 1'b0;
        total++; if (o_valid_a !== 1'b0 || i_ready_a !== 1'b1) begin bad++; $display("FAIL clr_state: got v=%0b r=%0b want 0 1", o_valid_a, i_ready_a); end
        for (int i = 0; i < 4; i++) beat(16'd1, 1'b0);
        total++; if (o_valid_a !== 1'b1 || o_sum_a !== 24'd4 || o_count_a !== 3'd4) begin bad++; $display("FAIL clr_frame: got v=%0b sum=%0d cnt=%0d want 1 4 4", o_valid_a, o_sum_a, o_count_a); end
        clr = 1'b1;
        tick();
        clr = 1'b0;
        total++; if (o_valid_a !== 1'b0 || i_ready_a !== 1'b1) begin bad++; $display("FAIL clr_hold_drop: got v=%0b r=%0b want 0 1", o_valid_a, i_ready_a); end
        o_ready = 1'b1;
        beat(16'd100, 1'b0); beat(16'd100, 1'b0);
        rst = 1'b0;
        #1;
        model_reset();
        total++; if ({i_ready_a, o_valid_a, o_ovf_a} !== 3'b0 || o_sum_a !== 24'd0 || o_count_a !== 3'd0) begin bad++; $display("FAIL rst_async: got r=%0b v=%0b ovf=%0b sum=%0d cnt=%0d want all 0", i_ready_a, o_valid_a, o_ovf_a, o_sum_a, o_count_a); end
        tick();
        rst = 1'b1;
        #1;
        total++; if (i_ready_a !== 1'b0) begin bad++; $display("FAIL rst_idle: got %0b want 0", i_ready_a); end
        tick();
        for (int i = 0; i < 4; i++) beat(16'd1, 1'b0);
        total++; if (o_valid_a !== 1'b1 || o_sum_a !== 24'd4 || o_count_a !== 3'd4) begin bad++; $display("FAIL rst_frame: got v=%0b sum=%0d cnt=%0d want 1 4 4", o_valid_a, o_sum_a, o_count_a); end
        tick();
    endtask

    task automatic test_random();
        for (int n = 0; n < 600; n++) begin
            i_valid = ($urandom_range(0, 3) != 0);
            i_data  = 16'($urandom_range(0, 65535));
            i_last  = ($urandom_range(0, 3) == 0);
            o_ready = ($urandom_range(0, 2) != 0);
            clr     = ($urandom_range(0, 59) == 0);
            tick();
            total++; if (i_ready_a !== m_ready || i_ready_b !== m_ready) begin bad++; $display("FAIL rnd_ready[%0d]: got %0b/%0b want %0b", n, i_ready_a, i_ready_b, m_ready); end
            total++; if (o_valid_a !== m_valid || o_valid_b !== m_valid) begin bad++; $display("FAIL rnd_valid[%0d]: got %0b/%0b want %0b", n, o_valid_a, o_valid_b, m_valid); end
            if (m_valid) begin
                total++; if (o_sum_a !== 24'(m_sum_a) || o_ovf_a !== m_ovf_a || o_count_a !== 3'(m_count)) begin bad++; $display("FAIL rnd_res24[%0d]: got %0d/%0b/%0d want %0d/%0b/%0d", n, o_sum_a, o_ovf_a, o_count_a, m_sum_a, m_ovf_a, m_count); end
                total++; if (o_sum_b !== 17'(m_sum_b) || o_ovf_b !== m_ovf_b || o_count_b !== 3'(m_count)) begin bad++; $display("FAIL rnd_res17[%0d]: got %0d/%0b/%0d want %0d/%0b/%0d", n, o_sum_b, o_ovf_b, o_count_b, m_sum_b, m_ovf_b, m_count); end
            end
        end
        clr = 1'b0; i_valid = 1'b0; i_last = 1'b0;
    endtask

    initial begin
        rst = 1'b0; clr = 1'b0; i_valid = 1'b0; i_last = 1'b0; o_ready = 1'b1; i_data = 16'd0;
        model_reset();
        test_reset();
        test_full_frame();
        test_early_last();
        test_saturation();
        test_backpressure();
        test_clr_rst();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
